// File: rtl/fuzz_sig_pkg.sv
// fuzz_sig_pkg
// Shared types and constants for the fuzz output signature compactor.
//   sig_state_e  : controller states (IDLE, WARM, RUN, HOLD)
//   DEF_POLY     : default MISR feedback polynomial (CRC-32 polynomial)
//   DEF_SEED     : default signature value loaded at the start of a window
//   fold_words() : number of SIG_W-bit chunks needed to cover DATA_W bits
// Optional feature macro used by the top: FUZZ_SIG_XCHK_EN.
package fuzz_sig_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } sig_state_e;

   localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

   // ceil(data_w / sig_w); usable in parameter expressions.
   function automatic int fold_words(input int data_w, input int sig_w);
      return (data_w + sig_w - 1) / sig_w;
   endfunction

endpackage

// File: rtl/fuzz_sig_fold.sv
// fuzz_sig_fold
// Purely combinational XOR fold of a DATA_W-bit bus into SIG_W bits.
// The bus is cut into SIG_W-bit chunks starting at bit 0; the top chunk is
// zero-padded, and all chunks are XORed together.
// Ports:
//   data_in  in  DATA_W  bus to be folded
//   fold     out SIG_W   XOR of all chunks
import fuzz_sig_pkg::*;

module fuzz_sig_fold #(
   parameter int DATA_W = 330,
   parameter int SIG_W  = 32
) (
   input  logic [DATA_W-1:0] data_in,
   output logic [SIG_W-1:0]  fold
);

   localparam int NW    = fold_words(DATA_W, SIG_W);
   localparam int PAD_W = NW * SIG_W;

   logic [PAD_W-1:0] padded;
   logic [SIG_W-1:0] chunk [NW];

   // Zero-extend to a whole number of chunks so the top chunk is padded.
   always_comb begin
      padded               = '0;
      padded[DATA_W-1:0]   = data_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NW; gi++) begin : g_chunk
         assign chunk[gi] = padded[gi*SIG_W +: SIG_W];
      end
   endgenerate

   always_comb begin
      fold = '0;
      for (int k = 0; k < NW; k++) begin
         fold = fold ^ chunk[k];
      end
   end

endmodule

// File: rtl/fuzz_sig_compactor.sv
// fuzz_sig_compactor
// Samples the fuzz DUT's flattened output bus every clock of a capture window
// (after a WARMUP-cycle discard period) and compresses it into a MISR
// signature, which is then offered over a valid/ready handshake together with
// the number of samples folded.
// Ports:
//   clk         in  1       single clock, rising edge
//   rst_n       in  1       asynchronous active-low reset
//   start       in  1       begin a capture window (accepted only in IDLE)
//   window      in  CNT_W   samples to fold, latched with start
//   data_in     in  DATA_W  observed DUT output bus
//   sig_valid   out 1       signature available (HOLD)
//   sig_ready   in  1       consumer accepts the signature
//   sig_out     out SIG_W   signature
//   sig_cycles  out CNT_W   samples folded
//   busy        out 1       registered, high in WARM or RUN
//   x_seen      out 1       sticky unknown-bit flag
// Configuration macro: FUZZ_SIG_XCHK_EN enables the X/Z check behind x_seen;
// without it x_seen is constant 0. Signatures are identical either way.
import fuzz_sig_pkg::*;

module fuzz_sig_compactor #(
   parameter int              DATA_W = 330,
   parameter int              SIG_W  = 32,
   parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
   parameter int unsigned     WARMUP = 2,
   parameter int              CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  window,
   input  logic [DATA_W-1:0] data_in,
   output logic              sig_valid,
   input  logic              sig_ready,
   output logic [SIG_W-1:0]  sig_out,
   output logic [CNT_W-1:0]  sig_cycles,
   output logic              busy,
   output logic              x_seen
);

   // Warm-up counter runs 0 .. WARMUP-1; sized to hold at least one bit.
   localparam int          WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int unsigned WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

   sig_state_e          state_reg, state_next;
   logic [CNT_W-1:0]    window_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [CNT_W-1:0]    count_inc;
   logic [SIG_W-1:0]    sig_reg;
   logic [SIG_W-1:0]    sig_step;
   logic [SIG_W-1:0]    fold;
   logic [WARM_W-1:0]   warm_cnt_reg;
   logic                busy_reg;
   logic                start_ok;

   fuzz_sig_fold #(
      .DATA_W (DATA_W),
      .SIG_W  (SIG_W)
   ) u_fold (
      .data_in (data_in),
      .fold    (fold)
   );

   // start is only honoured in IDLE; in particular it is dropped in the
   // HOLD transfer cycle, so the earliest restart is the cycle after.
   assign start_ok = (state_reg == IDLE) && start;

   // Saturating sample count; a window can never exceed the saturation
   // value, so saturation never hides the end-of-window match.
   assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg
                                                   : count_reg + CNT_W'(1);

   assign sig_step = {sig_reg[SIG_W-2:0], 1'b0}
                   ^ (sig_reg[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                   ^ fold;

   // ---------------- state register and datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         window_reg   <= '0;
         count_reg    <= '0;
         sig_reg      <= SEED;
         warm_cnt_reg <= '0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == WARM) || (state_next == RUN);
         case (state_reg)
            IDLE: begin
               if (start) begin
                  window_reg   <= window;
                  count_reg    <= '0;
                  sig_reg      <= SEED;
                  warm_cnt_reg <= '0;
               end
            end
            WARM: begin
               warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
            end
            RUN: begin
               sig_reg   <= sig_step;
               count_reg <= count_inc;
            end
            default: ;
         endcase
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               if (window == '0)
                  state_next = HOLD;
               else if (WARMUP > 0)
                  state_next = WARM;
               else
                  state_next = RUN;
            end
         end
         WARM: begin
            if (warm_cnt_reg == WARM_W'(WARM_LAST))
               state_next = RUN;
         end
         RUN: begin
            // count_inc is the count after this edge's sample.
            if (count_inc == window_reg)
               state_next = HOLD;
         end
         HOLD: begin
            if (sig_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      sig_valid  = (state_reg == HOLD);
      sig_out    = sig_reg;
      sig_cycles = count_reg;
      busy       = busy_reg;
   end

`ifdef FUZZ_SIG_XCHK_EN
   logic x_seen_reg;

   // Observation-only: the fold keeps using the raw value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         x_seen_reg <= 1'b0;
      else if (start_ok)
         x_seen_reg <= 1'b0;
      else if ((state_reg == RUN) && $isunknown(data_in))
         x_seen_reg <= 1'b1;
   end

   assign x_seen = x_seen_reg;
`else
   assign x_seen = 1'b0;
`endif

endmodule

// File: tb/tb_fuzz_sig_compactor.sv
// tb_fuzz_sig_compactor
// Directed, table-driven bench for fuzz_sig_compactor plus hand-written
// sequences for hold/stall, early ready, ignored start, mid-window reset and
// the unknown-bit flag (expectation follows FUZZ_SIG_XCHK_EN).
module tb_fuzz_sig_compactor;

   localparam int          DW     = 330;
   localparam int          SW     = 32;
   localparam int          CW     = 16;
   localparam int unsigned WARMUP = 2;
   localparam logic [31:0] POLY   = 32'h04C11DB7;
   localparam logic [31:0] SEED   = 32'hFFFFFFFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] window;
   logic [DW-1:0] data_in;
   logic          sig_valid;
   logic          sig_ready;
   logic [SW-1:0] sig_out;
   logic [CW-1:0] sig_cycles;
   logic          busy;
   logic          x_seen;

   int total = 0;
   int bad   = 0;

   fuzz_sig_compactor #(
      .DATA_W (DW),
      .SIG_W  (SW),
      .POLY   (POLY),
      .SEED   (SEED),
      .WARMUP (WARMUP),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .window     (window),
      .data_in    (data_in),
      .sig_valid  (sig_valid),
      .sig_ready  (sig_ready),
      .sig_out    (sig_out),
      .sig_cycles (sig_cycles),
      .busy       (busy),
      .x_seen     (x_seen)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit-wise reference: bit i of the bus lands on signature bit i mod SW.
   function automatic logic [31:0] m_step(input logic [31:0] s, input logic [DW-1:0] d);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < DW; i++) f[i % SW] = f[i % SW] ^ d[i];
      return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
      return d;
   endfunction

   typedef struct {
      logic [CW-1:0] win;
      logic [DW-1:0] data;
      logic [31:0]   exp_sig;
      logic [CW-1:0] exp_cyc;
   } vec_t;

   vec_t vecs [9];

   // One constant-data window: accept, wait for valid, compare, transfer.
   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int exp_lat;
      exp_lat = (v.win == 0) ? 0 : int'(WARMUP) + int'(v.win);
      data_in = v.data;
      window  = v.win;
      start   = 1'b1;
      tick();                       // E0
      start  = 1'b0;
      window = 16'hFFFF;            // must not affect the latched window
      check($sformatf("vec%0d_busy", idx), 64'(busy), 64'(v.win != 0));
      lat = 0;
      while (!sig_valid && lat < 200) begin
         tick();
         lat++;
      end
      check($sformatf("vec%0d_lat", idx), 64'(lat), 64'(exp_lat));
      check($sformatf("vec%0d_sig", idx), 64'(sig_out), 64'(v.exp_sig));
      check($sformatf("vec%0d_cyc", idx), 64'(sig_cycles), 64'(v.exp_cyc));
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check($sformatf("vec%0d_drop", idx), 64'(sig_valid), 64'(0));
   endtask

   // Random-data window compared against the reference model; optionally
   // pokes start during RUN and during the transfer cycle.
   task automatic model_run(input string tag, input int w, input bit poke);
      logic [31:0] exp_sig;
      start   = 1'b1;
      window  = CW'(w);
      data_in = rand_data();
      tick();                       // E0
      start   = 1'b0;
      exp_sig = SEED;
      for (int e = 1; e <= int'(WARMUP) + w; e++) begin
         data_in = rand_data();
         if (e > int'(WARMUP)) exp_sig = m_step(exp_sig, data_in);
         if (poke && e == int'(WARMUP) + 2) begin
            start  = 1'b1;
            window = CW'(1);
         end
         tick();
         start = 1'b0;
      end
      check({tag, "_valid"}, 64'(sig_valid), 64'(1));
      check({tag, "_sig"}, 64'(sig_out), 64'(exp_sig));
      check({tag, "_cyc"}, 64'(sig_cycles), 64'(w));
      sig_ready = 1'b1;
      start     = poke;
      tick();                       // transfer edge
      sig_ready = 1'b0;
      start     = 1'b0;
      check({tag, "_drop"}, 64'(sig_valid), 64'(0));
      check({tag, "_idle_busy"}, 64'(busy), 64'(0));
      tick();
      check({tag, "_still_idle"}, 64'(busy | sig_valid), 64'(0));
   endtask

   logic [DW-1:0] d;
   logic          exp_x;

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      window    = '0;
      data_in   = '0;
      sig_ready = 1'b0;

      // ---- vector table ----
      d = '0;                         vecs[0] = '{16'd1, d, 32'hFB3EE249, 16'd1};
      d = '0; d[0] = 1'b1; d[32] = 1'b1;  vecs[1] = '{16'd1, d, 32'hFB3EE249, 16'd1};
      d = '0; d[0] = 1'b1; d[320] = 1'b1; vecs[2] = '{16'd1, d, 32'hFB3EE249, 16'd1};
      d = '0; d[0] = 1'b1;            vecs[3] = '{16'd1, d, 32'hFB3EE248, 16'd1};
      d = '0; d[31] = 1'b1;           vecs[4] = '{16'd1, d, 32'h7B3EE249, 16'd1};
      d = '0; d[329] = 1'b1;          vecs[5] = '{16'd1, d, 32'hFB3EE049, 16'd1};
      d = '1;                         vecs[6] = '{16'd1, d, 32'hFB3EE1B6, 16'd1};
      d = '0;                         vecs[7] = '{16'd2, d, 32'hF2BCD925, 16'd2};
      d = '0; d[5] = 1'b1;            vecs[8] = '{16'd0, d, 32'hFFFFFFFF, 16'd0};

      // ---- reset state ----
      #12;
      check("rst_valid", 64'(sig_valid), 64'(0));
      check("rst_sig", 64'(sig_out), 64'(SEED));
      check("rst_cyc", 64'(sig_cycles), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_x", 64'(x_seen), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // ---- window 0 held for 5 stalled cycles ----
      window = '0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold%0d_valid", k), 64'(sig_valid), 64'(1));
         check($sformatf("hold%0d_sig", k), 64'(sig_out), 64'(SEED));
         check($sformatf("hold%0d_cyc", k), 64'(sig_cycles), 64'(0));
         tick();
      end
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check("hold_xfer", 64'(sig_valid), 64'(0));
      tick();

      // ---- ready high before valid: transfer on first HOLD cycle ----
      sig_ready = 1'b1;
      data_in   = '0;
      window    = 16'd1;
      start     = 1'b1;
      tick();                         // E0
      start = 1'b0;
      tick(); tick(); tick();         // E1..E3
      check("early_valid", 64'(sig_valid), 64'(1));
      check("early_sig", 64'(sig_out), 64'hFB3EE249);
      tick();
      check("early_drop", 64'(sig_valid), 64'(0));
      sig_ready = 1'b0;
      tick();

      // ---- start ignored in RUN and in the transfer cycle ----
      model_run("ign", 4, 1'b1);

      // ---- reset mid-RUN ----
      window = 16'd4;
      start  = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_in = rand_data();
         tick();
      end
      check("mid_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 64'(sig_valid), 64'(0));
      check("mrst_sig", 64'(sig_out), 64'(SEED));
      check("mrst_cyc", 64'(sig_cycles), 64'(0));
      check("mrst_busy", 64'(busy), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      model_run("post", 3, 1'b0);

      // ---- unknown bit during RUN ----
`ifdef FUZZ_SIG_XCHK_EN
      exp_x = 1'b1;
`else
      exp_x = 1'b0;
`endif
      data_in = '0;
      window  = 16'd2;
      start   = 1'b1;
      tick();                         // E0
      start = 1'b0;
      tick();                         // E1
      d = '0;
      d[200] = 1'bx;
      data_in = d;
      tick();                         // E2 (WARM, not checked)
      check("x_warm", 64'(x_seen), 64'(0));
      tick();                         // E3 samples the X
      data_in = '0;
      check("x_set", 64'(x_seen), 64'(exp_x));
      tick();                         // E4
      check("x_hold_valid", 64'(sig_valid), 64'(1));
      check("x_sticky", 64'(x_seen), 64'(exp_x));
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      check("x_after_xfer", 64'(x_seen), 64'(exp_x));
      window = 16'd1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      check("x_clear", 64'(x_seen), 64'(0));
      tick(); tick(); tick();
      check("x_clean_sig", 64'(sig_out), 64'hFB3EE249);
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
